// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: configuration
// checks, stage-count derivation and the result flag record.
package pipelined_addsub_pkg;

  typedef struct packed {
    logic cout;
    logic v;
  } addsub_flags_t;

  function automatic bit chunk_ok(input int width, input int chunk);
    return (width >= 32'sd1) && (chunk >= 32'sd1) && ((width % chunk) == 32'sd0);
  endfunction

  function automatic int calc_stages(input int width, input int chunk);
    return (chunk >= 32'sd1) ? (width / chunk) : 32'sd1;
  endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// One CHUNK-bit ripple stage: registers its sum, carry out and the carry
// into its top bit (used for signed overflow on the last stage).
module addsub_slice
  import pipelined_addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             cin_s,
  output logic [CHUNK-1:0] sum_r,
  output logic             cout_r,
  output logic             cmsb_r
);

  logic [CHUNK:0] total_s;
  logic           cmsb_s;

  // Chunk sum; carry into the MSB is recovered from the MSB sum bit
  always_comb begin
    total_s = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, cin_s};
    cmsb_s  = total_s[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
  end

  // Stage registers with stall and reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      cmsb_r <= 1'b0;
    end else if (ce) begin
      sum_r  <= total_s[CHUNK-1:0];
      cout_r <= total_s[CHUNK];
      cmsb_r <= cmsb_s;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: carry chain registered every CHUNK bits,
// operands skewed in and sums deskewed out so one result leaves per cycle.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             VALID_IN,
  input  logic             SUB,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             V,
  output logic             VALID_OUT
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  typedef struct packed {
    logic [WIDTH-1:0] o;
    addsub_flags_t    flags;
  } result_t;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  logic [WIDTH-1:0]             b_adj_s;
  logic                         c0_s;
  logic [STAGES-1:0][CHUNK-1:0] slc_sum_s;
  logic [STAGES-1:0]            slc_cout_s;
  logic [STAGES-1:0][CHUNK-1:0] out_chunk_s;
  logic                         last_cmsb_s;
  logic [STAGES-1:0]            vld_r;
  result_t                      res_s;

  // Subtract is A + ~B with the borrow-in turned into an inverted carry-in
  always_comb begin
    if (SUB) begin
      b_adj_s = ~I1;
      c0_s    = ~CIN;
    end else begin
      b_adj_s = I1;
      c0_s    = CIN;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_k_s;
    logic [CHUNK-1:0] b_k_s;
    logic             cin_k_s;

    if (k == 0) begin : g_direct
      assign a_k_s   = I0[CHUNK-1:0];
      assign b_k_s   = b_adj_s[CHUNK-1:0];
      assign cin_k_s = c0_s;
    end else begin : g_skew
      logic [CHUNK-1:0] a_dly_r [k];
      logic [CHUNK-1:0] b_dly_r [k];

      // Delay chunk k of the operands by k cycles to meet its carry
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int j = 0; j < k; j++) begin
            a_dly_r[j] <= '0;
            b_dly_r[j] <= '0;
          end
        end else if (CE) begin
          a_dly_r[0] <= I0[k*CHUNK +: CHUNK];
          b_dly_r[0] <= b_adj_s[k*CHUNK +: CHUNK];
          for (int j = 1; j < k; j++) begin
            a_dly_r[j] <= a_dly_r[j-1];
            b_dly_r[j] <= b_dly_r[j-1];
          end
        end
      end

      assign a_k_s   = a_dly_r[k-1];
      assign b_k_s   = b_dly_r[k-1];
      assign cin_k_s = slc_cout_s[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .clk    (CLK),
        .reset  (RESET),
        .ce     (CE),
        .a_s    (a_k_s),
        .b_s    (b_k_s),
        .cin_s  (cin_k_s),
        .sum_r  (slc_sum_s[k]),
        .cout_r (slc_cout_s[k]),
        .cmsb_r (last_cmsb_s)
      );
      assign out_chunk_s[k] = slc_sum_s[k];
    end else begin : g_mid
      localparam int DESKEW = STAGES - 1 - k;
      logic             unused_cmsb_s;
      logic [CHUNK-1:0] ds_r [DESKEW];

      addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .clk    (CLK),
        .reset  (RESET),
        .ce     (CE),
        .a_s    (a_k_s),
        .b_s    (b_k_s),
        .cin_s  (cin_k_s),
        .sum_r  (slc_sum_s[k]),
        .cout_r (slc_cout_s[k]),
        .cmsb_r (unused_cmsb_s)
      );

      // Hold early chunks back until the top chunk catches up
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int j = 0; j < DESKEW; j++) begin
            ds_r[j] <= '0;
          end
        end else if (CE) begin
          ds_r[0] <= slc_sum_s[k];
          for (int j = 1; j < DESKEW; j++) begin
            ds_r[j] <= ds_r[j-1];
          end
        end
      end

      assign out_chunk_s[k] = ds_r[DESKEW-1];
    end
  end

  // Valid tag travels alongside the data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_r <= '0;
    end else if (CE) begin
      vld_r[0] <= VALID_IN;
      for (int j = 1; j < STAGES; j++) begin
        vld_r[j] <= vld_r[j-1];
      end
    end
  end

  assign res_s.o          = out_chunk_s;
  assign res_s.flags.cout = slc_cout_s[STAGES-1];
  assign res_s.flags.v    = slc_cout_s[STAGES-1] ^ last_cmsb_s;

  assign O         = res_s.o;
  assign COUT      = res_s.flags.cout;
  assign V         = res_s.flags.v;
  assign VALID_OUT = vld_r[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, CHUNK=4): directed vectors,
// bubbles, stalls, reset flush and a short randomised run against a model.
module tb_pipelined_addsub;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = 4;

  typedef enum int {EK_NONE, EK_RST, EK_ADV, EK_STALL} edge_kind_t;

  typedef struct {
    logic [WIDTH-1:0] o;
    logic             c;
    logic             v;
    int               due;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RESET, CE, VALID_IN, SUB, CIN;
  logic [WIDTH-1:0] I0, I1;
  logic [WIDTH-1:0] O;
  logic             COUT, V, VALID_OUT;

  exp_t       sb[$];
  edge_kind_t ek = EK_NONE;
  int         ce_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .VALID_IN(VALID_IN), .SUB(SUB),
    .I0(I0), .I1(I1), .CIN(CIN), .O(O), .COUT(COUT), .V(V), .VALID_OUT(VALID_OUT)
  );

  always #5 CLK = ~CLK;

  // Classify each rising edge from the inputs the bench is driving
  initial begin
    forever begin
      @(posedge CLK);
      if (RESET) begin
        ek = EK_RST;
        sb.delete();
      end else if (CE) begin
        ek = EK_ADV;
        ce_cnt++;
      end else begin
        ek = EK_STALL;
      end
    end
  end

  // Monitor: compare on the falling edge
  initial begin
    logic [WIDTH+2:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (ek == EK_RST) begin
        n_checks++;
        if (VALID_OUT !== 1'b0 || O !== 16'h0000 || COUT !== 1'b0 || V !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state: got vld=%b O=%h C=%b V=%b, expected all zero",
                   VALID_OUT, O, COUT, V);
        end
      end else if (ek == EK_STALL) begin
        n_checks++;
        if ({VALID_OUT, O, COUT, V} !== prev) begin
          n_fail++;
          $display("FAIL stall_hold: got %h, expected held %h", {VALID_OUT, O, COUT, V}, prev);
        end
      end else if (ek == EK_ADV) begin
        if (VALID_OUT === 1'b1) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: got O=%h at edge %0d, expected no result", O, ce_cnt);
          end else begin
            e = sb.pop_front();
            if (O !== e.o || COUT !== e.c || V !== e.v) begin
              n_fail++;
              $display("FAIL result: got O=%h C=%b V=%b, expected O=%h C=%b V=%b",
                       O, COUT, V, e.o, e.c, e.v);
            end
            n_checks++;
            if (ce_cnt != e.due) begin
              n_fail++;
              $display("FAIL latency: got edge %0d, expected edge %0d", ce_cnt, e.due);
            end
          end
        end else if (sb.size() != 0 && sb[0].due <= ce_cnt) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing: got vld=%b at edge %0d, expected O=%h due at edge %0d",
                   VALID_OUT, ce_cnt, sb[0].o, sb[0].due);
          void'(sb.pop_front());
        end
      end
      prev = {VALID_OUT, O, COUT, V};
    end
  end

  task automatic drive(input logic rst, input logic ce, input logic vin, input logic sub,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input logic [WIDTH-1:0] eo, input logic ec, input logic ev);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET = rst; CE = ce; VALID_IN = vin; SUB = sub; I0 = a; I1 = b; CIN = cin;
    if (!rst && ce && vin) begin
      e.o = eo; e.c = ec; e.v = ev; e.due = ce_cnt + STAGES;
      sb.push_back(e);
    end
  endtask

  task automatic op(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic cin, input logic [WIDTH-1:0] eo, input logic ec, input logic ev);
    drive(1'b0, 1'b1, 1'b1, sub, a, b, cin, eo, ec, ev);
  endtask

  task automatic idle(input logic ce);
    drive(1'b0, ce, ~ce, 1'b1, 16'(($urandom)), 16'(($urandom)), 1'b1, 16'h0000, 1'b0, 1'b0);
  endtask

  function automatic logic [WIDTH+1:0] ref_model(input logic sub, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] bb;
    logic             c0, ov;
    bb = sub ? ~b : b;
    c0 = sub ? ~cin : cin;
    s  = {1'b0, a} + {1'b0, bb} + {16'h0000, c0};
    ov = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {ov, s};
  endfunction

  initial begin
    logic [WIDTH+1:0] r;
    logic             rs, rc;
    logic [WIDTH-1:0] ra, rb;
    RESET = 1'b1; CE = 1'b0; VALID_IN = 1'b0; SUB = 1'b0; I0 = '0; I1 = '0; CIN = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h0, 1'b0, 1'b0);

    // Directed arithmetic and boundary vectors, back to back
    op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    op(1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);
    op(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    op(1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Mixed stream with a single bubble
    op(1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    op(1'b1, 16'h5000, 16'h1000, 1'b0, 16'h4000, 1'b1, 1'b0);
    idle(1'b1);
    op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(1'b1, 16'h0001, 16'h0002, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Three ops in flight, then a two-cycle stall with junk on the inputs
    op(1'b0, 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
    op(1'b1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0);
    op(1'b0, 16'hA000, 16'hA000, 1'b0, 16'h4000, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);
    repeat (6) idle(1'b1);

    // Three ops in flight, then reset: none may emerge
    op(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    op(1'b0, 16'h4444, 16'h1111, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(1'b1, 16'h9999, 16'h1111, 1'b0, 16'h8888, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0);
    op(1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    repeat (6) idle(1'b1);

    // Randomised traffic with stalls and bubbles against the model
    for (int i = 0; i < 400; i++) begin
      rs = 1'($urandom_range(1));
      rc = 1'($urandom_range(1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      r  = ref_model(rs, ra, rb, rc);
      drive(1'b0, ($urandom_range(9) != 0), ($urandom_range(4) != 0), rs, ra, rb, rc,
            r[WIDTH-1:0], r[WIDTH], r[WIDTH+1]);
    end

    repeat (8) idle(1'b1);
    @(negedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
